// File: rtl/axi_lite_reg_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : axi_lite_reg_responder                                        |
// | Purpose  : AXI4-Lite slave register bank, NUM_REGS x 32-bit, with        |
// |            byte-strobed writes and per-register commit strobes.          |
// | Option   : define REG_SLVERR_EN to answer out-of-bank addresses with     |
// |            SLVERR instead of aliasing them into the bank.                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module axi_lite_reg_responder #(
  parameter int NUM_REGS   = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic [ADDR_WIDTH-1:0]    S_AXI_AWADDR,
  input  logic [2:0]               S_AXI_AWPROT,
  input  logic                     S_AXI_AWVALID,
  output logic                     S_AXI_AWREADY,
  input  logic [31:0]              S_AXI_WDATA,
  input  logic [3:0]               S_AXI_WSTRB,
  input  logic                     S_AXI_WVALID,
  output logic                     S_AXI_WREADY,
  output logic [1:0]               S_AXI_BRESP,
  output logic                     S_AXI_BVALID,
  input  logic                     S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]    S_AXI_ARADDR,
  input  logic [2:0]               S_AXI_ARPROT,
  input  logic                     S_AXI_ARVALID,
  output logic                     S_AXI_ARREADY,
  output logic [31:0]              S_AXI_RDATA,
  output logic [1:0]               S_AXI_RRESP,
  output logic                     S_AXI_RVALID,
  input  logic                     S_AXI_RREADY,
  output logic [NUM_REGS*32-1:0]   reg_out,
  output logic [NUM_REGS-1:0]      reg_wr_stb
);

  localparam int       c_ADDR_LSB = 2;
  localparam int       c_IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [1:0] c_OKAY   = 2'b00;
  localparam logic [1:0] c_SLVERR = 2'b10;

  localparam logic [1:0] W_IDLE    = 2'd0;
  localparam logic [1:0] W_HAVE_AW = 2'd1;
  localparam logic [1:0] W_HAVE_W  = 2'd2;
  localparam logic [1:0] W_RESP    = 2'd3;

  localparam logic R_IDLE = 1'b0;
  localparam logic R_DATA = 1'b1;

  logic [1:0]              r_wstate, w_wstate_nxt;
  logic                    r_rstate, w_rstate_nxt;
  logic [ADDR_WIDTH-1:0]   r_awaddr;
  logic [31:0]             r_wdata;
  logic [3:0]              r_wstrb;
  logic [1:0]              r_bresp;
  logic [1:0]              r_rresp;
  logic [31:0]             r_rdata;
  logic [NUM_REGS-1:0]     r_wr_stb;
  logic [NUM_REGS*32-1:0]  w_bank;

  logic                    w_aw_hs, w_w_hs, w_ar_hs;
  logic                    w_commit, w_wr_en, w_wr_err, w_rd_err;
  logic [ADDR_WIDTH-1:0]   w_cmt_addr;
  logic [31:0]             w_cmt_data;
  logic [3:0]              w_cmt_strb;
  logic [c_IDX_W-1:0]      w_wr_idx, w_rd_idx;
  logic                    w_unused;

  assign w_aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_w_hs  = S_AXI_WVALID  & S_AXI_WREADY;
  assign w_ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

  // The half of the pair that arrived earlier comes from the holding register.
  assign w_commit   = ((r_wstate == W_IDLE)    & w_aw_hs & w_w_hs) |
                      ((r_wstate == W_HAVE_AW) & w_w_hs) |
                      ((r_wstate == W_HAVE_W)  & w_aw_hs);
  assign w_cmt_addr = (r_wstate == W_HAVE_AW) ? r_awaddr : S_AXI_AWADDR;
  assign w_cmt_data = (r_wstate == W_HAVE_W)  ? r_wdata  : S_AXI_WDATA;
  assign w_cmt_strb = (r_wstate == W_HAVE_W)  ? r_wstrb  : S_AXI_WSTRB;
  assign w_wr_idx   = w_cmt_addr[c_ADDR_LSB +: c_IDX_W];
  assign w_rd_idx   = S_AXI_ARADDR[c_ADDR_LSB +: c_IDX_W];

`ifdef REG_SLVERR_EN
  assign w_wr_err = |w_cmt_addr[ADDR_WIDTH-1:c_ADDR_LSB+c_IDX_W];
  assign w_rd_err = |S_AXI_ARADDR[ADDR_WIDTH-1:c_ADDR_LSB+c_IDX_W];
`else
  assign w_wr_err = 1'b0;
  assign w_rd_err = 1'b0;
`endif

  assign w_wr_en  = w_commit & ~w_wr_err;
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, w_cmt_addr, S_AXI_ARADDR};

  // ---------------- write FSM ----------------
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_wstate <= W_IDLE;
    else          r_wstate <= w_wstate_nxt;
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) w_wstate_nxt = W_RESP;
        else if (w_aw_hs)      w_wstate_nxt = W_HAVE_AW;
        else if (w_w_hs)       w_wstate_nxt = W_HAVE_W;
      end
      W_HAVE_AW: if (w_w_hs)       w_wstate_nxt = W_RESP;
      W_HAVE_W:  if (w_aw_hs)      w_wstate_nxt = W_RESP;
      W_RESP:    if (S_AXI_BREADY) w_wstate_nxt = W_IDLE;
      default:   w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    case (r_wstate)
      W_IDLE:    begin S_AXI_AWREADY = 1'b1; S_AXI_WREADY = 1'b1; end
      W_HAVE_AW: S_AXI_WREADY  = 1'b1;
      W_HAVE_W:  S_AXI_AWREADY = 1'b1;
      W_RESP:    S_AXI_BVALID  = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_bresp  <= c_OKAY;
      r_wr_stb <= '0;
    end else begin
      if (w_aw_hs) r_awaddr <= S_AXI_AWADDR;
      if (w_w_hs) begin
        r_wdata <= S_AXI_WDATA;
        r_wstrb <= S_AXI_WSTRB;
      end
      if (w_commit) r_bresp <= w_wr_err ? c_SLVERR : c_OKAY;
      r_wr_stb <= '0;
      if (w_wr_en && (|w_cmt_strb)) r_wr_stb <= NUM_REGS'(1) << w_wr_idx;
    end
  end

  // ---------------- register bank ----------------
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [31:0] r_q;
    always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
        r_q <= '0;
      end else if (w_wr_en && (w_wr_idx == c_IDX_W'(gi))) begin
        for (int b = 0; b < 4; b++) begin
          if (w_cmt_strb[b]) r_q[8*b +: 8] <= w_cmt_data[8*b +: 8];
        end
      end
    end
    assign w_bank[32*gi +: 32] = r_q;
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_rstate <= R_IDLE;
    else          r_rstate <= w_rstate_nxt;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs)      w_rstate_nxt = R_DATA;
      R_DATA:  if (S_AXI_RREADY) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    S_AXI_ARREADY = (r_rstate == R_IDLE);
    S_AXI_RVALID  = (r_rstate == R_DATA);
  end

  // Bank is sampled before this edge's write lands, so a colliding read sees old data.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rdata <= '0;
      r_rresp <= c_OKAY;
    end else if (w_ar_hs) begin
      r_rdata <= w_rd_err ? 32'd0 : w_bank[32*w_rd_idx +: 32];
      r_rresp <= w_rd_err ? c_SLVERR : c_OKAY;
    end
  end

  assign S_AXI_BRESP = r_bresp;
  assign S_AXI_RDATA = r_rdata;
  assign S_AXI_RRESP = r_rresp;
  assign reg_out     = w_bank;
  assign reg_wr_stb  = r_wr_stb;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_reg_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_axi_lite_reg_responder                                     |
// | Purpose  : directed self-checking bench for axi_lite_reg_responder       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_axi_lite_reg_responder;

  logic         tb_ACLK = 1'b0;
  logic         tb_ARESETN = 1'b0;
  logic [31:0]  awaddr = '0, araddr = '0, wdata = '0;
  logic [2:0]   awprot = '0, arprot = '0;
  logic [3:0]   wstrb = '0;
  logic         awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic         bready = 1'b1, rready = 1'b1;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic [127:0] reg_out;
  logic [3:0]   reg_wr_stb;

  int n_vec = 0;
  int n_mis = 0;

  always #5 tb_ACLK = ~tb_ACLK;

  axi_lite_reg_responder #(.NUM_REGS(4), .ADDR_WIDTH(32)) dut (
    .ACLK(tb_ACLK), .ARESETN(tb_ARESETN),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .reg_wr_stb(reg_wr_stb)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // AW and W together; BREADY assumed high so the response retires next edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] exp_resp, input logic [3:0] exp_stb, input string tag);
    @(negedge tb_ACLK);
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
    @(posedge tb_ACLK); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    chk({tag, ".bvalid"}, bvalid, 1'b1);
    chk({tag, ".bresp"}, bresp, exp_resp);
    chk({tag, ".stb"}, reg_wr_stb, exp_stb);
    @(posedge tb_ACLK); #1;
    chk({tag, ".idle"}, {bvalid, awready, wready, reg_wr_stb}, 7'b011_0000);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp_d, input logic [1:0] exp_resp,
                    input string tag);
    @(negedge tb_ACLK);
    araddr = a; arvalid = 1'b1;
    @(posedge tb_ACLK); #1;
    arvalid = 1'b0;
    chk({tag, ".rvalid"}, rvalid, 1'b1);
    chk({tag, ".rdata"}, rdata, exp_d);
    chk({tag, ".rresp"}, rresp, exp_resp);
    @(posedge tb_ACLK); #1;
    chk({tag, ".idle"}, {rvalid, arready}, 2'b01);
  endtask

  initial begin
    repeat (3) @(posedge tb_ACLK);
    @(negedge tb_ACLK) tb_ARESETN = 1'b1;
    @(posedge tb_ACLK); #1;
    chk("rst.reg_out", reg_out, 128'd0);
    chk("rst.ctl", {awready, wready, arready, bvalid, rvalid, bresp, rresp, reg_wr_stb}, 13'b11100_0000_0000);
    chk("rst.rdata", rdata, 32'd0);

    // four aligned writes, then read back
    wr(32'h0, 32'h0101FFFF, 4'hF, 2'b00, 4'b0001, "w0");
    wr(32'h4, 32'hABCD0001, 4'hF, 2'b00, 4'b0010, "w1");
    wr(32'h8, 32'hDEAD0011, 4'hF, 2'b00, 4'b0100, "w2");
    wr(32'hC, 32'hBEEF0011, 4'hF, 2'b00, 4'b1000, "w3");
    chk("bank", reg_out, {32'hBEEF0011, 32'hDEAD0011, 32'hABCD0001, 32'h0101FFFF});
    rd(32'h0, 32'h0101FFFF, 2'b00, "r0");
    rd(32'h4, 32'hABCD0001, 2'b00, "r1");
    rd(32'h8, 32'hDEAD0011, 2'b00, "r2");
    rd(32'hC, 32'hBEEF0011, 2'b00, "r3");

    // write and read of reg0 on the same edge: read sees the old value
    @(negedge tb_ACLK);
    awaddr = 32'h0; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h0; arvalid = 1'b1;
    @(posedge tb_ACLK); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("same.rdata", rdata, 32'h0101FFFF);
    chk("same.valid", {bvalid, rvalid, reg_wr_stb}, 6'b11_0001);
    @(posedge tb_ACLK); #1;
    rd(32'h0, 32'hCAFEF00D, 2'b00, "same.rd2");

    // W three cycles ahead of AW
    @(negedge tb_ACLK);
    wdata = 32'h13572468; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge tb_ACLK); #1;
    wvalid = 1'b0;
    chk("wfirst.wait", {awready, wready, bvalid}, 3'b100);
    repeat (2) @(posedge tb_ACLK);
    #1 chk("wfirst.hold", {awready, wready, bvalid}, 3'b100);
    @(negedge tb_ACLK);
    awaddr = 32'h4; awvalid = 1'b1;
    @(posedge tb_ACLK); #1;
    awvalid = 1'b0;
    chk("wfirst.resp", {bvalid, reg_wr_stb}, 5'b1_0010);
    chk("wfirst.reg1", reg_out[63:32], 32'h13572468);
    @(posedge tb_ACLK); #1;
    chk("wfirst.once", bvalid, 1'b0);

    // AW ahead of W
    @(negedge tb_ACLK);
    awaddr = 32'h8; awvalid = 1'b1;
    @(posedge tb_ACLK); #1;
    awvalid = 1'b0;
    chk("awfirst.wait", {awready, wready, bvalid}, 3'b010);
    @(negedge tb_ACLK);
    wdata = 32'h2468ACE0; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge tb_ACLK); #1;
    wvalid = 1'b0;
    chk("awfirst.resp", {bvalid, reg_wr_stb}, 5'b1_0100);
    @(posedge tb_ACLK); #1;
    chk("awfirst.once", bvalid, 1'b0);
    rd(32'h4, 32'h13572468, 2'b00, "split.r1");
    rd(32'h8, 32'h2468ACE0, 2'b00, "split.r2");

    // byte strobes
    wr(32'h0, 32'hFFFFFFFF, 4'hF, 2'b00, 4'b0001, "strb.full");
    wr(32'h0, 32'h12345678, 4'b0101, 2'b00, 4'b0001, "strb.part");
    rd(32'h0, 32'hFF34FF78, 2'b00, "strb.rd");
    wr(32'h0, 32'h00000000, 4'b0000, 2'b00, 4'b0000, "strb.none");
    rd(32'h0, 32'hFF34FF78, 2'b00, "strb.rd0");

    // write response backpressure
    bready = 1'b0;
    @(negedge tb_ACLK);
    awaddr = 32'hC; wdata = 32'h11112222; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge tb_ACLK); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("bp.b", {bvalid, awready, wready, bresp}, 5'b1_0_0_00);
      @(posedge tb_ACLK); #1;
    end
    @(negedge tb_ACLK) bready = 1'b1;
    @(posedge tb_ACLK); #1;
    chk("bp.bdone", {bvalid, awready, wready}, 3'b011);

    // read response backpressure; ARADDR moves while RVALID is held
    rready = 1'b0;
    @(negedge tb_ACLK);
    araddr = 32'hC; arvalid = 1'b1;
    @(posedge tb_ACLK); #1;
    arvalid = 1'b0; araddr = 32'h0;
    for (int i = 0; i < 10; i++) begin
      chk("bp.r", {rvalid, arready, rresp, rdata}, {1'b1, 1'b0, 2'b00, 32'h11112222});
      @(posedge tb_ACLK); #1;
    end
    @(negedge tb_ACLK) rready = 1'b1;
    @(posedge tb_ACLK); #1;
    chk("bp.rdone", {rvalid, arready}, 2'b01);

    // address above the bank
`ifdef REG_SLVERR_EN
    wr(32'h10, 32'hA5A5A5A5, 4'hF, 2'b10, 4'b0000, "oob.w");
    rd(32'h10, 32'h00000000, 2'b10, "oob.r");
    rd(32'h0, 32'hFF34FF78, 2'b00, "oob.r0");
`else
    wr(32'h10, 32'hA5A5A5A5, 4'hF, 2'b00, 4'b0001, "alias.w");
    rd(32'h10, 32'hA5A5A5A5, 2'b00, "alias.r");
    rd(32'h0, 32'hA5A5A5A5, 2'b00, "alias.r0");
`endif

    // reset with a half-done write and an unaccepted read response outstanding
    @(negedge tb_ACLK);
    awaddr = 32'h4; awvalid = 1'b1;
    @(posedge tb_ACLK); #1;
    awvalid = 1'b0;
    rready = 1'b0;
    @(negedge tb_ACLK);
    araddr = 32'h8; arvalid = 1'b1;
    @(posedge tb_ACLK); #1;
    arvalid = 1'b0;
    chk("mid.pre", {rvalid, awready}, 2'b10);
    #2 tb_ARESETN = 1'b0;
    #1;
    chk("mid.reg_out", reg_out, 128'd0);
    chk("mid.ctl", {awready, wready, arready, bvalid, rvalid, bresp, rresp, reg_wr_stb}, 13'b11100_0000_0000);
    chk("mid.rdata", rdata, 32'd0);
    @(negedge tb_ACLK);
    tb_ARESETN = 1'b1; rready = 1'b1;
    @(posedge tb_ACLK); #1;
    @(negedge tb_ACLK);
    wdata = 32'h77778888; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge tb_ACLK); #1;
    wvalid = 1'b0;
    chk("mid.discard", {awready, wready, bvalid}, 3'b100);
    chk("mid.nocommit", reg_out, 128'd0);
    @(negedge tb_ACLK);
    awaddr = 32'hC; awvalid = 1'b1;
    @(posedge tb_ACLK); #1;
    awvalid = 1'b0;
    chk("mid.resp", {bvalid, reg_wr_stb}, 5'b1_1000);
    chk("mid.bank", reg_out, {32'h77778888, 96'd0});
    @(posedge tb_ACLK); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_lite_reg_responder.md
# axi_lite_reg_responder

AXI4-Lite slave-side register bank: accepts single-beat writes and reads from an AXI4-Lite master, holds `NUM_REGS` 32-bit registers, and presents their contents to native fabric logic. It sits behind the interconnect as the responder for register-space traffic issued by masters (BFM in simulation, processor/NoC bridge in hardware). Write and read channels are fully independent; AW and W may arrive in any order.

## Interface
- `NUM_REGS`, 4, number of 32-bit registers (power of two, 2..64)
- `ADDR_WIDTH`, 32, AXI address width; decode uses bits `[ADDR_LSB+log2(NUM_REGS)-1:ADDR_LSB]`, `ADDR_LSB`=2
- `ACLK`  in  1  clock, all logic on rising edge
- `ARESETN`  in  1  asynchronous active-low reset
- `S_AXI_AWADDR`  in  ADDR_WIDTH  write address; `S_AXI_AWPROT` in 3, ignored
- `S_AXI_AWVALID` in 1 / `S_AXI_AWREADY` out 1  write-address handshake
- `S_AXI_WDATA` in 32; `S_AXI_WSTRB` in 4  byte lane enables
- `S_AXI_WVALID` in 1 / `S_AXI_WREADY` out 1  write-data handshake
- `S_AXI_BRESP` out 2; `S_AXI_BVALID` out 1 / `S_AXI_BREADY` in 1  write response
- `S_AXI_ARADDR` in ADDR_WIDTH; `S_AXI_ARPROT` in 3, ignored
- `S_AXI_ARVALID` in 1 / `S_AXI_ARREADY` out 1  read-address handshake
- `S_AXI_RDATA` out 32; `S_AXI_RRESP` out 2; `S_AXI_RVALID` out 1 / `S_AXI_RREADY` in 1
- `reg_out`  out  NUM_REGS*32  register contents, reg i at `[32i+31:32i]`
- `reg_wr_stb`  out  NUM_REGS  one-cycle pulse per register on commit

## Operation
- Write FSM: `W_IDLE`, `W_HAVE_AW`, `W_HAVE_W`, `W_RESP`.
  - `W_IDLE`: AWREADY=WREADY=1. Both handshake same edge -> commit, `W_RESP`. AW only -> latch addr, `W_HAVE_AW`. W only -> latch data/strb, `W_HAVE_W`.
  - `W_HAVE_AW`: AWREADY=0, WREADY=1; W handshake -> commit, `W_RESP`. `W_HAVE_W` symmetric.
  - `W_RESP`: AWREADY=WREADY=0, BVALID=1; BVALID&BREADY -> `W_IDLE`.
- Commit: for each lane b with WSTRB[b]=1, reg[idx][8b+7:8b] <= WDATA lane; `reg_wr_stb[idx]` pulses one cycle after commit edge. WSTRB=0 commits nothing, still responds, no strobe.
- Read FSM: `R_IDLE` (ARREADY=1), `R_DATA` (ARREADY=0, RVALID=1). AR handshake captures RDATA from current register values; RVALID&RREADY -> `R_IDLE`.
- Index decode ignores address bits below ADDR_LSB (unaligned addresses act as aligned) and above the index field unless `REG_SLVERR_EN` is defined.
- BRESP/RRESP = OKAY (2'b00) unless an error is flagged (see Configuration).

## Timing
- Reset (async assert, sync release on ACLK): all registers 0, `reg_out`=0, `reg_wr_stb`=0, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, FSMs idle, AWREADY=WREADY=ARREADY=1 from first cycle after release.
- Reset mid-transaction: pending addr/data discarded, no commit, outstanding BVALID/RVALID dropped.
- Write latency: commit at edge of final AW/W handshake; BVALID high the following cycle. Max throughput one write per 2 cycles with BREADY=1.
- Read latency: RVALID high the cycle after AR handshake; one read per 2 cycles with RREADY=1.
- BVALID/RVALID, BRESP/RRESP/RDATA stable until accepted (backpressure holds indefinitely).
- Simultaneous commit and AR handshake to same register on same edge: read returns the pre-write value.
- Readiness outputs are registered-state decodes; no combinational path from any VALID/READY input to any READY/VALID output.

## Configuration
- `REG_SLVERR_EN` defined: any address with nonzero bits above the index field (relative to the base, i.e. `addr >= NUM_REGS*4`) returns SLVERR (2'b10); writes do not commit, no strobe; reads return RDATA=0.
- Undefined: upper bits ignored, address aliases into the bank, responses always OKAY.

## Test plan
- Write 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to offsets 0x0,0x4,0x8,0xC (AW/W together), read back each -> matching RDATA, BRESP=RRESP=OKAY, `reg_wr_stb` one-hot pulses 0001..1000.
- W presented 3 cycles before AW to 0x4, then AW before W to 0x8 -> both commit correctly; BVALID once per write, one cycle after final handshake.
- Reg0=0xFFFFFFFF, write 0x12345678 with WSTRB=4'b0101 -> reg0=0xFF34FF78; WSTRB=0 -> unchanged, OKAY, no strobe.
- BREADY/RREADY low 10 cycles -> BVALID/RVALID and RDATA held constant, AWREADY/ARREADY stay 0 until accepted.
- Same-edge write 0xCAFEF00D and read of 0x0 (old 0x0101FFFF) -> RDATA=0x0101FFFF, next read 0xCAFEF00D.
- With `REG_SLVERR_EN`, write/read at 0x10 -> BRESP=RRESP=2'b10, RDATA=0, reg0 unchanged; without it -> OKAY, aliases reg0; ARESETN pulsed mid-write -> all outputs return to reset values.
